// File: rtl/fns_serial_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : fns_serial_encoder_if
// Purpose  : Input/output handshake bundle for the serial Fibonacci
//            (Zeckendorf) encoder. The upstream word side carries
//            data_in/valid_in/ready_out. The downstream codeword side carries
//            cw_out/err_out/valid_out/ready_in.
// Revision : 1.0 - initial release
// ============================================================================
interface fns_serial_encoder_if #(
    parameter int DATA_W = 6,
    parameter int CW_W   = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic [CW_W-1:0]   cw_out;
    logic              err_out;
    logic              valid_out;
    logic              ready_in;

    // Encoder side: consumes words, produces codewords
    modport slave (
        input  data_in, valid_in, ready_in,
        output ready_out, cw_out, err_out, valid_out
    );

    // Environment side: produces words, consumes codewords
    modport master (
        output data_in, valid_in, ready_in,
        input  ready_out, cw_out, err_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/fns_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module   : fns_serial_encoder
// Purpose  : Serial Zeckendorf encoder. It walks the Fibonacci weights from
//            the top down and resolves one codeword bit per clock. It raises
//            err_out for inputs above the largest encodable value.
// Options  : FNS_SELFCHECK_EN - adds selfchk_err_out, which re-sums the
//            produced codeword. The output flags a sum mismatch or any
//            adjacent pair of 1s.
// Revision : 1.0 - initial release
// ============================================================================
module fns_serial_encoder #(
    parameter int DATA_W = 6,
    parameter int CW_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    fns_serial_encoder_if.slave bus
`ifdef FNS_SELFCHECK_EN
    ,
    output logic                selfchk_err_out
`endif
);
    localparam int DW    = DATA_W + 1;
    localparam int IDX_W = (CW_W > 1) ? $clog2(CW_W) : 1;

    // Fibonacci weight i with w[0]=1, w[1]=2.
    // A legal instantiation needs w[CW_W] < 2**(DATA_W+1).
    function automatic int fib_w(input int i);
        int a;
        int b;
        int t;
        a = 1;
        b = 2;
        if (i == 0) return 1;
        for (int k = 1; k < i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam logic [DW-1:0] c_W_HI_INIT = DW'(fib_w(CW_W - 1));
    localparam logic [DW-1:0] c_W_LO_INIT = DW'(fib_w(CW_W - 2));
    localparam logic [DW-1:0] c_MAX       = DW'(fib_w(CW_W) - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]      r_state_q, w_state_d;
    logic [DW-1:0]   r_rem_q,   w_rem_d;
    logic [DW-1:0]   r_w_hi_q,  w_w_hi_d;
    logic [DW-1:0]   r_w_lo_q,  w_w_lo_d;
    logic [IDX_W-1:0] r_idx_q,  w_idx_d;
    logic [CW_W-1:0] r_cw_q,    w_cw_d;
    logic [CW_W-1:0] r_cw_out_q, w_cw_out_d;
    logic            r_err_out_q, w_err_out_d;
    logic            w_accept;
    logic            w_range_err;
    logic            w_last_bit;
    logic            w_ready_out;
    logic            w_valid_out;
`ifdef FNS_SELFCHECK_EN
    logic [DW-1:0]   r_acc_q,  w_acc_d;
    logic [DW-1:0]   r_data_q, w_data_d;
    logic            r_selfchk_q, w_selfchk_d;
`endif

    assign w_accept    = bus.valid_in & w_ready_out;
    assign w_range_err = ({1'b0, bus.data_in} > c_MAX);
    assign w_last_bit  = (r_idx_q == '0);

    // State and datapath registers; reset discards any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_S_IDLE;
            r_rem_q     <= '0;
            r_w_hi_q    <= '0;
            r_w_lo_q    <= '0;
            r_idx_q     <= '0;
            r_cw_q      <= '0;
            r_cw_out_q  <= '0;
            r_err_out_q <= 1'b0;
`ifdef FNS_SELFCHECK_EN
            r_acc_q     <= '0;
            r_data_q    <= '0;
            r_selfchk_q <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_rem_q     <= w_rem_d;
            r_w_hi_q    <= w_w_hi_d;
            r_w_lo_q    <= w_w_lo_d;
            r_idx_q     <= w_idx_d;
            r_cw_q      <= w_cw_d;
            r_cw_out_q  <= w_cw_out_d;
            r_err_out_q <= w_err_out_d;
`ifdef FNS_SELFCHECK_EN
            r_acc_q     <= w_acc_d;
            r_data_q    <= w_data_d;
            r_selfchk_q <= w_selfchk_d;
`endif
        end
    end

    // Next state: out-of-range words skip BUSY; DONE waits for downstream
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_S_IDLE: if (w_accept)     w_state_d = w_range_err ? c_S_DONE : c_S_BUSY;
            c_S_BUSY: if (w_last_bit)   w_state_d = c_S_DONE;
            c_S_DONE: if (bus.ready_in) w_state_d = c_S_IDLE;
            default:                    w_state_d = c_S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        w_ready_out = (r_state_q == c_S_IDLE);
        w_valid_out = (r_state_q == c_S_DONE);
    end

    // Greedy descent: take the current weight when it fits, then step the weights down one place
    always_comb begin
        w_rem_d     = r_rem_q;
        w_w_hi_d    = r_w_hi_q;
        w_w_lo_d    = r_w_lo_q;
        w_idx_d     = r_idx_q;
        w_cw_d      = r_cw_q;
        w_cw_out_d  = r_cw_out_q;
        w_err_out_d = r_err_out_q;
`ifdef FNS_SELFCHECK_EN
        w_acc_d     = r_acc_q;
        w_data_d    = r_data_q;
        w_selfchk_d = r_selfchk_q;
`endif
        case (r_state_q)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_rem_d  = {1'b0, bus.data_in};
                    w_w_hi_d = c_W_HI_INIT;
                    w_w_lo_d = c_W_LO_INIT;
                    w_idx_d  = IDX_W'(CW_W - 1);
                    w_cw_d   = '0;
`ifdef FNS_SELFCHECK_EN
                    w_acc_d  = '0;
                    w_data_d = {1'b0, bus.data_in};
`endif
                    if (w_range_err) begin
                        w_cw_out_d  = '0;
                        w_err_out_d = 1'b1;
`ifdef FNS_SELFCHECK_EN
                        w_selfchk_d = 1'b0;
`endif
                    end else begin
                        w_err_out_d = 1'b0;
                    end
                end
            end
            c_S_BUSY: begin
                if (r_rem_q >= r_w_hi_q) begin
                    w_cw_d[r_idx_q] = 1'b1;
                    w_rem_d         = r_rem_q - r_w_hi_q;
`ifdef FNS_SELFCHECK_EN
                    w_acc_d         = r_acc_q + r_w_hi_q;
`endif
                end
                // Below w[1]=2, w[0]=1 gives w_lo = 2-1 = 1 as the last weight
                w_w_hi_d = r_w_lo_q;
                w_w_lo_d = r_w_hi_q - r_w_lo_q;
                w_idx_d  = r_idx_q - 1'b1;
                if (w_last_bit) begin
                    w_cw_out_d = w_cw_d;
`ifdef FNS_SELFCHECK_EN
                    w_selfchk_d = (w_acc_d != r_data_q) | (|(w_cw_d & (w_cw_d >> 1)));
`endif
                end
            end
            default: ;
        endcase
    end

    assign bus.ready_out = w_ready_out;
    assign bus.valid_out = w_valid_out;
    assign bus.cw_out    = r_cw_out_q;
    assign bus.err_out   = r_err_out_q;
`ifdef FNS_SELFCHECK_EN
    assign selfchk_err_out = r_selfchk_q;
`endif
endmodule
`default_nettype wire
